fta_bus_arbiter: RTL and testbench
==================================

// Module: fta_bus_arbiter
// PURPOSE
//  Round-robin arbiter sharing one fta_cmd_request128 master port among NREQ requesters.
//  Requesters: icache ctrl, data ports, TLB walker. Sits between the core-side masters and the MPU external bus.
//  Grant is registered, locks for the duration of a cyc burst, and is bounded by a hold limit.
//  Returns responses to the owner by tid.channel, tracks outstanding reads per requester, and counts misrouted responses.
// PARAMETERS
//  NREQ      4    number of requesters (2..8)
//  CH_BASE   0    tid.channel value of requester 0; requester i owns channel CH_BASE+i
//  MAX_HOLD  16   max consecutive grant cycles before forced re-arbitration (1..255)
//  MAX_OUTS  4    max outstanding read requests per requester (1..15)
//  PRI0      0    1: requester 0 wins any contested arbitration (RR among the rest)
// PORTS
//  clk        in   1                   clock
//  rst_n      in   1                   reset, synchronous, active-low
//  req_i      in   NREQ x request128   requester commands (fta_cmd_request128_t)
//  resp_o     out  NREQ x response128  per-requester response (fta_cmd_response128_t)
//  fta_req    out  request128          external bus command
//  fta_resp   in   response128         external bus response
//  gnt_o      out  NREQ                one-hot current grant, 0 when idle
//  busy_o     out  1                   state != IDLE
//  drop_cnt_o out  16                  count of responses whose channel maps to no requester
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge):
//   - state=IDLE, gnt_o=0, fta_req=0, hold count=0, RR pointer=0.
//   - All outstanding counters=0, drop_cnt_o=0.
//   - resp_o[i]=0 except rty=1.
//   - Reset mid-burst drops the grant immediately. No response is replayed.
//  Eligible(i) = req_i[i].cyc && !(read && outs[i]==MAX_OUTS). A read is we=0.
//  States:
//   IDLE:
//    - If any requester is eligible, pick the winner: first eligible at or after the RR pointer.
//      If PRI0=1, requester 0 wins when eligible.
//    - Register gnt_o, hold=1, go to GRANT.
//    - No grant is issued in the decision cycle.
//    - Latency: cyc seen in cycle n means fta_req=req_i[w] in cycle n+1.
//   GRANT:
//    - fta_req = req_i[g] (combinational mux on registered grant).
//    - Each cycle that fta_req.cyc && !fta_resp.rty counts as accepted: hold++.
//    - Exit when req_i[g].cyc falls, hold reaches MAX_HOLD, or g becomes ineligible.
//    - On exit: RR pointer=g+1 mod NREQ, gnt_o=0, go to PARK.
//   PARK:
//    - One dead cycle with fta_req=0 and gnt_o=0. Then IDLE.
//    - Guarantees bus turnaround and a fair re-arbitration point.
//  Retry to requesters:
//   - Non-granted requester i: resp_o[i].rty=1, tid=req_i[i].tid.
//   - Granted requester: resp_o[g].rty = fta_resp.rty.
//  Response routing (same cycle, combinational):
//   - If fta_resp.ack and tid.channel-CH_BASE is in [0,NREQ), copy fta_resp to that resp_o and clear its rty.
//   - Out-of-range channel: drop, drop_cnt_o++ (saturates at 16'hFFFF).
//  Outstanding counters (4 bits):
//   - outs[g]++ when a read is accepted.
//   - outs[i]-- on a routed ack to requester i.
//   - Same-cycle ++ and -- on one counter: net unchanged.
//   - Decrement at 0 is ignored.
//  Simultaneous events: when the grant drops in the same cycle as the last accept, the accept still counts.
//  Width rule: hold counter is 8 bits. The compare is ==MAX_HOLD, so no wrap is reachable.
// TESTING
//  1. Single requester: req_i[1].cyc=1 at cycle 5.
//     -> gnt_o=4'b0010 at cycle 6; fta_req matches req_i[1] at cycle 6.
//  2. RR fairness: all 4 hold cyc continuously, MAX_HOLD=16, rty=0.
//     -> grants 0,1,2,3,0, each 16 cycles, one PARK cycle between.
//  3. PRI0=1: req 0 and 2 contend.
//     -> 0 wins every arbitration; 2 is granted only when 0 is idle.
//  4. Outstanding limit MAX_OUTS=4: requester 1 issues 4 reads with no ack.
//     -> masked out; first ack on channel CH_BASE+1 re-enables it.
//  5. Routing: ack with channel=7, NREQ=4, CH_BASE=0.
//     -> all resp_o acks stay 0; drop_cnt_o goes 0->1.
//  6. rst_n=0 mid-GRANT with outs[2]=3.
//     -> next cycle gnt_o=0, fta_req=0, outs all 0, state IDLE.

Source files
------------

// File: rtl/fta_bus_arbiter.sv
// fta_bus_arbiter
//   Round-robin arbiter that shares one fta_cmd_request128 master port among
//   NREQ requesters (icache ctrl, data ports, TLB walker) in front of the MPU
//   external bus. The grant is registered, held for a cyc burst, and capped at
//   MAX_HOLD accepted cycles. Responses return to their owner by tid.channel.
//   Outstanding reads are tracked per requester, and misrouted acks are counted.
// Ports
//   clk, rst_n  clock, synchronous active-low reset
//   req_i       per-requester commands
//   resp_o      per-requester responses (rty=1 while not granted)
//   fta_req     external bus command (muxed from the granted requester)
//   fta_resp    external bus response
//   gnt_o       one-hot registered grant, 0 when idle
//   busy_o      arbiter not idle
//   drop_cnt_o  saturating count of acks whose channel maps to no requester
package fta_bus_pkg;
    typedef struct packed {
        logic [3:0] core;
        logic [3:0] channel;
        logic [7:0] tranid;
    } fta_tid_t;

    typedef struct packed {
        fta_tid_t     tid;
        logic         cyc;
        logic         stb;
        logic         we;
        logic [15:0]  sel;
        logic [31:0]  adr;
        logic [127:0] dat;
    } fta_cmd_request128_t;

    typedef struct packed {
        fta_tid_t     tid;
        logic         ack;
        logic         rty;
        logic         err;
        logic [31:0]  adr;
        logic [127:0] dat;
    } fta_cmd_response128_t;
endpackage

module fta_bus_arbiter
    import fta_bus_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int CH_BASE  = 0,
    parameter int MAX_HOLD = 16,
    parameter int MAX_OUTS = 4,
    parameter int PRI0     = 0
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  fta_cmd_request128_t  [NREQ-1:0]       req_i,
    output fta_cmd_response128_t [NREQ-1:0]       resp_o,
    output fta_cmd_request128_t                   fta_req,
    input  fta_cmd_response128_t                  fta_resp,
    output logic                 [NREQ-1:0]       gnt_o,
    output logic                                  busy_o,
    output logic                 [15:0]           drop_cnt_o
);
    localparam int IW = $clog2(NREQ);
    localparam logic [4:0] CH_BASE_W = 5'(CH_BASE);
    localparam logic [4:0] NREQ_W    = 5'(NREQ);

    typedef enum logic [1:0] {IDLE, GRANT, PARK} state_t;

    state_t                 state, state_nx;
    logic [IW-1:0]          gidx, gidx_nx, rr_ptr, rr_ptr_nx, win;
    logic [NREQ-1:0]        gnt_nx, elig;
    logic [7:0]             hold, hold_nx;
    logic [NREQ-1:0][3:0]   outs, outs_nx;
    logic                   found, exit_g, accept, acc_rd, in_rng, rt_hit;
    logic [4:0]             ch_off;
    logic [IW-1:0]          rt_idx;

    // A requester with a full outstanding-read budget is masked only for reads.
    always_comb begin
        for (int i = 0; i < NREQ; i++)
            elig[i] = req_i[i].cyc && !(!req_i[i].we && outs[i] == 4'(MAX_OUTS));
    end

    // First eligible at or after the RR pointer; requester 0 overrides when PRI0.
    always_comb begin
        win   = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && elig[(int'(rr_ptr) + k) % NREQ]) begin
                win   = IW'((int'(rr_ptr) + k) % NREQ);
                found = 1'b1;
            end
        end
        if (PRI0 != 0 && elig[0])
            win = '0;
    end

    // The forwarded command is suppressed once the owner turns ineligible, so a
    // read beyond the outstanding budget never reaches the bus in the exit cycle.
    always_comb begin
        fta_req = '0;
        if (state == GRANT && elig[gidx])
            fta_req = req_i[gidx];
    end

    assign accept = (state == GRANT) && fta_req.cyc && !fta_resp.rty;
    assign acc_rd = accept && !fta_req.we;
    assign exit_g = !elig[gidx] || hold == 8'(MAX_HOLD);
    assign busy_o = (state != IDLE);

    // Channels below CH_BASE wrap to a large offset and fall out of range.
    assign ch_off = {1'b0, fta_resp.tid.channel} - CH_BASE_W;
    assign in_rng = ch_off < NREQ_W;
    assign rt_hit = fta_resp.ack && in_rng;
    assign rt_idx = ch_off[IW-1:0];

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            resp_o[i]     = '0;
            resp_o[i].tid = req_i[i].tid;
            resp_o[i].rty = gnt_o[i] ? fta_resp.rty : 1'b1;
            if (rt_hit && rt_idx == IW'(i)) begin
                resp_o[i]     = fta_resp;
                resp_o[i].rty = 1'b0;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            outs_nx[i] = outs[i];
            case ({acc_rd && gnt_o[i], rt_hit && rt_idx == IW'(i) && outs[i] != 4'd0})
                2'b10:   outs_nx[i] = outs[i] + 4'd1;
                2'b01:   outs_nx[i] = outs[i] - 4'd1;
                default: outs_nx[i] = outs[i];
            endcase
        end
    end

    always_comb begin
        state_nx  = state;
        gnt_nx    = gnt_o;
        gidx_nx   = gidx;
        hold_nx   = hold;
        rr_ptr_nx = rr_ptr;
        case (state)
            IDLE: begin
                if (found) begin
                    gnt_nx      = '0;
                    gnt_nx[win] = 1'b1;
                    gidx_nx     = win;
                    hold_nx     = 8'd1;
                    state_nx    = GRANT;
                end
            end
            GRANT: begin
                if (exit_g) begin
                    rr_ptr_nx = (gidx == IW'(NREQ - 1)) ? '0 : gidx + 1'b1;
                    gnt_nx    = '0;
                    state_nx  = PARK;
                end else if (accept) begin
                    hold_nx = hold + 8'd1;
                end
            end
            PARK:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            gnt_o      <= '0;
            gidx       <= '0;
            hold       <= '0;
            rr_ptr     <= '0;
            outs       <= '0;
            drop_cnt_o <= '0;
        end else begin
            state  <= state_nx;
            gnt_o  <= gnt_nx;
            gidx   <= gidx_nx;
            hold   <= hold_nx;
            rr_ptr <= rr_ptr_nx;
            outs   <= outs_nx;
            if (fta_resp.ack && !in_rng && drop_cnt_o != 16'hFFFF)
                drop_cnt_o <= drop_cnt_o + 16'd1;
        end
    end
endmodule

// File: tb/tb_fta_bus_arbiter.sv
module tb_fta_bus_arbiter;
    import fta_bus_pkg::*;

    localparam int NR = 4, CHB = 0, MH = 16, MO = 4;
    typedef fta_cmd_request128_t  [NR-1:0] req_vec_t;
    typedef fta_cmd_response128_t [NR-1:0] resp_vec_t;

    logic                 clk = 1'b0;
    logic                 rst_n;
    req_vec_t             req;
    fta_cmd_response128_t fresp;
    resp_vec_t            resp0, resp1;
    fta_cmd_request128_t  fq0, fq1;
    logic [NR-1:0]        g0, g1;
    logic                 b0, b1;
    logic [15:0]          d0, d1;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    fta_bus_arbiter #(.NREQ(NR), .CH_BASE(CHB), .MAX_HOLD(MH), .MAX_OUTS(MO), .PRI0(0)) dut (
        .clk(clk), .rst_n(rst_n), .req_i(req), .resp_o(resp0), .fta_req(fq0),
        .fta_resp(fresp), .gnt_o(g0), .busy_o(b0), .drop_cnt_o(d0));

    fta_bus_arbiter #(.NREQ(NR), .CH_BASE(CHB), .MAX_HOLD(MH), .MAX_OUTS(MO), .PRI0(1)) dut_p (
        .clk(clk), .rst_n(rst_n), .req_i(req), .resp_o(resp1), .fta_req(fq1),
        .fta_resp(fresp), .gnt_o(g1), .busy_o(b1), .drop_cnt_o(d1));

    // Reference model: phase 0 idle, 1 owner holds the bus, 2 turnaround.
    typedef struct {
        int phase;
        int own;
        int hold;
        int rr;
        int outs[NR];
        int drop;
    } mdl_t;
    mdl_t m0, m1;

    task automatic ck(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic bit m_elig(input mdl_t m, input int i);
        return req[i].cyc && !(!req[i].we && m.outs[i] == MO);
    endfunction

    function automatic int m_route();
        int ch = int'(fresp.tid.channel) - CHB;
        if (fresp.ack && ch >= 0 && ch < NR) return ch;
        return -1;
    endfunction

    function automatic int m_bus(input mdl_t m);
        return (m.phase == 1 && m_elig(m, m.own)) ? m.own : -1;
    endfunction

    task automatic m_reset(output mdl_t m);
        m.phase = 0; m.own = 0; m.hold = 0; m.rr = 0; m.drop = 0;
        for (int i = 0; i < NR; i++) m.outs[i] = 0;
    endtask

    task automatic m_step(inout mdl_t m, input bit pri0);
        int b = m_bus(m);
        int r = m_route();
        int w = -1;
        bit acc;
        int old[NR];
        if (!rst_n) begin
            m_reset(m);
            return;
        end
        acc = (b >= 0) && !fresp.rty;
        for (int i = 0; i < NR; i++) old[i] = m.outs[i];
        case (m.phase)
            0: begin
                if (pri0 && m_elig(m, 0)) w = 0;
                else for (int k = 0; k < NR; k++)
                    if (w < 0 && m_elig(m, (m.rr + k) % NR)) w = (m.rr + k) % NR;
                if (w >= 0) begin m.phase = 1; m.own = w; m.hold = 1; end
            end
            1: begin
                if (!m_elig(m, m.own) || m.hold == MH) begin
                    m.rr = (m.own + 1) % NR;
                    m.phase = 2;
                end else if (acc) m.hold++;
            end
            default: m.phase = 0;
        endcase
        for (int i = 0; i < NR; i++) begin
            if (acc && b == i && !req[i].we) m.outs[i]++;
            if (r == i && old[i] > 0) m.outs[i]--;
        end
        if (fresp.ack && r < 0 && m.drop < 65535) m.drop++;
    endtask

    task automatic chk_dut(input string nm, input mdl_t m, input logic [NR-1:0] g,
                           input fta_cmd_request128_t fq, input resp_vec_t rs,
                           input logic b, input logic [15:0] d);
        int bo = m_bus(m);
        int r = m_route();
        logic [NR-1:0] eg = '0;
        fta_cmd_request128_t efq = '0;
        fta_cmd_response128_t er;
        if (m.phase == 1) eg[m.own] = 1'b1;
        if (bo >= 0) efq = req[bo];
        ck({nm, " gnt"}, 256'(g), 256'(eg));
        ck({nm, " fta_req"}, 256'(fq), 256'(efq));
        for (int i = 0; i < NR; i++) begin
            er = '0;
            er.tid = req[i].tid;
            er.rty = (m.phase == 1 && m.own == i) ? fresp.rty : 1'b1;
            if (r == i) begin er = fresp; er.rty = 1'b0; end
            ck($sformatf("%s resp%0d", nm, i), 256'(rs[i]), 256'(er));
        end
        ck({nm, " busy"}, 256'(b), 256'(m.phase != 0));
        ck({nm, " drop"}, 256'(d), 256'(m.drop));
    endtask

    // Inputs change at negedge; outputs are checked 1 time unit later.
    task automatic step();
        #1;
        chk_dut("arb", m0, g0, fq0, resp0, b0, d0);
        chk_dut("arbp", m1, g1, fq1, resp1, b1, d1);
        m_step(m0, 1'b0);
        m_step(m1, 1'b1);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req = '0; fresp = '0;
        step(); step();
        rst_n = 1'b1;
    endtask

    task automatic set_req(input int i, input logic cyc, input logic we);
        req[i].cyc         = cyc;
        req[i].stb         = cyc;
        req[i].we          = we;
        req[i].sel         = 16'hFFFF;
        req[i].adr         = $urandom;
        req[i].dat         = {$urandom, $urandom, $urandom, $urandom};
        req[i].tid.channel = 4'(i + CHB);
        req[i].tid.tranid  = 8'($urandom);
    endtask

    typedef struct {
        logic       ack;
        logic [3:0] ch;
        logic       rty;
        logic [3:0] ack_v;
        logic [3:0] rty_v;
        int         drop_inc;
    } rvec_t;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog");
    end

    initial begin
        rvec_t tv[7];
        logic [NR-1:0] samp0[$], samp1[$];
        int rv[$], rl[$], gl[$];
        logic [NR-1:0] prev;
        logic [3:0] av, rtv;
        fta_cmd_response128_t er;
        int len, expd, other, zero_cnt;
        bit found;

        tv[0] = '{1'b1, 4'd7,  1'b0, 4'b0000, 4'b1111, 1};
        tv[1] = '{1'b1, 4'd2,  1'b0, 4'b0100, 4'b1011, 0};
        tv[2] = '{1'b1, 4'd0,  1'b1, 4'b0001, 4'b1110, 0};
        tv[3] = '{1'b0, 4'd3,  1'b0, 4'b0000, 4'b1111, 0};
        tv[4] = '{1'b1, 4'd4,  1'b0, 4'b0000, 4'b1111, 1};
        tv[5] = '{1'b1, 4'd3,  1'b1, 4'b1000, 4'b0111, 0};
        tv[6] = '{1'b1, 4'd15, 1'b0, 4'b0000, 4'b1111, 1};

        rst_n = 1'b0; req = '0; fresp = '0;
        @(negedge clk);
        m_reset(m0); m_reset(m1);
        do_reset();

        // Reset state
        ck("reset gnt", 256'(g0), 256'(0));
        ck("reset fta_req", 256'(fq0), 256'(0));
        ck("reset busy", 256'(b0), 256'(0));
        ck("reset drop", 256'(d0), 256'(0));
        er = '0; er.rty = 1'b1;
        for (int i = 0; i < NR; i++) ck($sformatf("reset resp%0d", i), 256'(resp0[i]), 256'(er));

        // Single requester: one decision cycle, then the grant
        repeat (3) step();
        set_req(1, 1'b1, 1'b1);
        ck("t1 busy in decision cycle", 256'(b0), 256'(0));
        step();
        ck("t1 gnt", 256'(g0), 256'(4'b0010));
        ck("t1 fta_req", 256'(fq0), 256'(req[1]));
        req[1] = '0;
        repeat (4) step();

        // RR fairness, and PRI0 instance seeing the same contention
        do_reset();
        for (int i = 0; i < NR; i++) set_req(i, 1'b1, 1'b1);
        repeat (92) begin
            step();
            samp0.push_back(g0);
            samp1.push_back(g1);
        end
        prev = '0; len = 0;
        foreach (samp0[k]) begin
            if (samp0[k] == prev) len++;
            else begin
                if (prev != 0) begin rv.push_back(int'(prev)); rl.push_back(len); end
                else if (rv.size() > 0) gl.push_back(len);
                prev = samp0[k]; len = 1;
            end
        end
        ck("t2 complete grants", 256'(rv.size() >= 5), 256'(1));
        for (int r = 0; r < 5 && r < rv.size(); r++) begin
            ck($sformatf("t2 grant%0d owner", r), 256'(rv[r]), 256'(1 << (r % NR)));
            ck($sformatf("t2 grant%0d length", r), 256'(rl[r]), 256'(MH));
        end
        // Gap is the PARK cycle plus the grant-less IDLE decision cycle.
        for (int r = 0; r < 4 && r < gl.size(); r++)
            ck($sformatf("t2 gap%0d", r), 256'(gl[r]), 256'(2));
        other = 0; zero_cnt = 0;
        foreach (samp1[k]) begin
            if (samp1[k] == 4'b0001) zero_cnt++;
            else if (samp1[k] != 4'b0000) other++;
        end
        ck("t3 pri0 others granted", 256'(other), 256'(0));
        ck("t3 pri0 req0 granted", 256'(zero_cnt > 0), 256'(1));
        req[0] = '0; req[1] = '0; req[3] = '0;
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            step();
            if (g1 == 4'b0100) found = 1'b1;
        end
        ck("t3 req2 granted once req0 idle", 256'(found), 256'(1));
        req = '0;
        repeat (4) step();

        // Outstanding-read limit
        do_reset();
        set_req(1, 1'b1, 1'b0);
        repeat (12) step();
        ck("t4 masked gnt", 256'(g0), 256'(0));
        ck("t4 masked busy", 256'(b0), 256'(0));
        ck("t4 masked fta cyc", 256'(fq0.cyc), 256'(0));
        fresp.ack = 1'b1; fresp.tid.channel = 4'(1 + CHB);
        step();
        fresp = '0;
        found = 1'b0;
        for (int k = 0; k < 6 && !found; k++) begin
            step();
            if (g0 == 4'b0010) found = 1'b1;
        end
        ck("t4 re-enabled after ack", 256'(found), 256'(1));
        req = '0;
        repeat (6) step();

        // Routing table while idle
        do_reset();
        expd = 0;
        foreach (tv[k]) begin
            fresp = '0;
            fresp.ack = tv[k].ack;
            fresp.rty = tv[k].rty;
            fresp.tid.channel = tv[k].ch;
            fresp.dat = {$urandom, $urandom, $urandom, $urandom};
            #1;
            for (int i = 0; i < NR; i++) begin av[i] = resp0[i].ack; rtv[i] = resp0[i].rty; end
            ck($sformatf("t5 vec%0d ack", k), 256'(av), 256'(tv[k].ack_v));
            ck($sformatf("t5 vec%0d rty", k), 256'(rtv), 256'(tv[k].rty_v));
            step();
            expd += tv[k].drop_inc;
            ck($sformatf("t5 vec%0d drop", k), 256'(d0), 256'(expd));
        end
        fresp = '0;

        // Reset in the middle of a grant
        do_reset();
        set_req(2, 1'b1, 1'b0);
        repeat (4) step();
        ck("t6 outs2 before reset", 256'(dut.outs[2]), 256'(3));
        ck("t6 granted before reset", 256'(g0), 256'(4'b0100));
        rst_n = 1'b0;
        step();
        ck("t6 gnt after reset", 256'(g0), 256'(0));
        ck("t6 fta_req after reset", 256'(fq0), 256'(0));
        ck("t6 busy after reset", 256'(b0), 256'(0));
        ck("t6 outs after reset", 256'(dut.outs), 256'(0));
        rst_n = 1'b1;
        req = '0;
        step();

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            rst_n = ($urandom_range(0, 499) != 0);
            for (int i = 0; i < NR; i++)
                if ($urandom_range(0, 7) == 0)
                    set_req(i, !req[i].cyc, 1'($urandom_range(0, 1)));
            fresp = '0;
            fresp.ack = ($urandom_range(0, 3) == 0);
            fresp.rty = ($urandom_range(0, 4) == 0);
            fresp.err = 1'($urandom_range(0, 1));
            fresp.tid.channel = 4'($urandom_range(0, 7));
            fresp.tid.tranid = 8'($urandom);
            fresp.adr = $urandom;
            fresp.dat = {$urandom, $urandom, $urandom, $urandom};
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
